fetch_parcel_sequencer: RTL and testbench
=========================================

// Module: fetch_parcel_sequencer
// PURPOSE
// Sequences the fifo_adapter read port to hand whole RV32IC instructions to decode.
// Peeks each parcel and picks the read size: 16-bit if rdata[1:0]!=2'b11, else 32-bit.
// Splits 32-bit instructions that straddle a 16B line into two 16-bit reads.
// On redirect, flushes the fetch queue and skips parcels ahead of the target PC.
// PARAMETERS
// BOOT_PC     32'h0000_0000  PC of first instruction after reset (bit 0 ignored)
// LINE_BYTES  16             bytes per fetch line; must match the adapter line width
// PORTS
// clk_i               in   1   clock
// rstn_i              in   1   reset; one clock, synchronous, active-low
// adp_empty_i         in   1   adapter holds no readable parcel
// adp_rdata_i         in   32  adapter head data; valid same cycle when !adp_empty_i
// adp_re_o            out  1   consume rsize bytes from adapter at this clock edge
// adp_rsize_o         out  1   0: 16-bit read, 1: 32-bit read
// fetch_flush_o       out  1   1-cycle pulse; resets upstream fifo and adapter
// redirect_i          in   1   branch/exception redirect request
// redirect_pc_i       in   32  redirect target
// instr_o             out  32  instruction; compressed parcels zero-extended
// instr_pc_o          out  32  PC of instr_o
// instr_compressed_o  out  1   instr_o is a 16-bit instruction
// instr_valid_o       out  1   instr_o is valid (valid/ready handshake)
// instr_ready_i       in   1   decode accepts instr_o this cycle
// BEHAVIOUR
// Reset:
// - instr_valid_o=0, adp_re_o=0, fetch_flush_o=0.
// - pc_q=BOOT_PC&~1, offset_q=0, skip_q=BOOT_PC[3:1], state=SKIP.
// Adapter contract:
// - Reads have zero latency: data is sampled while !adp_empty_i; adp_re_o consumes at the edge.
// - adp_re_o is never asserted while adp_empty_i=1.
// offset_q[3:0]:
// - Byte position inside the current line.
// - Advances by 2 or 4 per read and wraps mod LINE_BYTES.
// SKIP:
// - If skip_q!=0 and !empty: re=1, rsize=0, skip_q--, offset+=2.
// - When skip_q==0, go to FETCH.
// FETCH, when !empty, three cases:
// - Compressed (rdata[1:0]!=11): re, rsize=0, latch {16'b0,rdata[15:0]}, go to OUT.
// - 32-bit with offset_q!=14: re, rsize=1, latch rdata[31:0], go to OUT.
// - 32-bit with offset_q==14: re, rsize=0, latch low half, go to FETCH_HI (line split).
// FETCH_HI:
// - When !empty: re, rsize=0, instr[31:16]=rdata[15:0], go to OUT.
// OUT:
// - instr_valid_o=1; outputs held stable until instr_ready_i.
// - On accept: pc_q += compressed?2:4.
// - On accept, the FETCH actions are evaluated in the same cycle, so back-to-back delivery gives 1 instr/cycle.
// - If the adapter is empty on accept, go to FETCH.
// Redirect (highest priority, any state):
// - That cycle: fetch_flush_o=1, adp_re_o=0, and any pending instruction is dropped.
// - Next cycle: instr_valid_o=0, pc_q=redirect_pc_i&~1, offset_q=0, skip_q=redirect_pc_i[3:1], state=SKIP.
// - Redirect concurrent with accept: the accept completes; the redirect still wins for the next state.
// Width rules:
// - PC arithmetic is 32-bit and wraps silently.
// - offset_q is 4-bit and wraps naturally.
// Reset mid-operation: all state returns to reset values on the next edge; no partial instruction survives.
// STRUCTURE
// fetch_pkg holds:
// - typedef enum {SKIP, FETCH, FETCH_HI, OUT} fseq_state_e.
// - localparam LINE_BYTES_DEF = 16.
// - function is_compressed(logic [1:0]).
// No sub-module: single FSM plus datapath registers (pc_q, offset_q, skip_q, instr_q, hi/lo latch).
// TESTING
// 1. BOOT_PC=0; line {0x00000013, 0x4501, 0x4581, 0x00A00093..} -> instr 0x13@0, 0x4501@4 (c=1), 0x4581@6.
// 2. 32-bit instr at byte 14 split across lines -> two 16-bit reads, one output with 32-bit instr_o, pc=0x0E.
// 3. Redirect to 0x106 -> flush pulse 1 cycle; 3 parcels skipped; first valid instr_pc_o=0x106.
// 4. instr_ready_i low 5 cycles in OUT -> instr_o/instr_pc_o stable, adp_re_o=0 throughout.
// 5. Redirect asserted same cycle as accept and as FETCH_HI -> no stale instr delivered; next pc = target.
// 6. adp_empty_i toggling every cycle with random ready -> adp_re_o never high while empty; PC sequence matches model.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the fetch parcel sequencer
package fetch_pkg;
  typedef enum logic [1:0] {SKIP, FETCH, FETCH_HI, OUT} fseq_state_e;
  localparam int LINE_BYTES_DEF = 16;
  function automatic logic is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction
endpackage

// File: rtl/fetch_parcel_sequencer.sv
// fetch_parcel_sequencer: drives the adapter read port and hands whole RV32IC instructions to decode
module fetch_parcel_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC    = 32'h0000_0000,
  parameter int          LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        adp_empty_i,
  input  logic [31:0] adp_rdata_i,
  output logic        adp_re_o,
  output logic        adp_rsize_o,
  output logic        fetch_flush_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam logic [OW-1:0] LAST = OW'(LINE_BYTES - 2);
  fseq_state_e   state_q;
  logic [31:0]   pc_q, instr_q;
  logic [OW-1:0] offset_q;
  logic [OW-2:0] skip_q;
  logic          comp_q, comp, split, accept, fetch_go;
  assign comp     = is_compressed(adp_rdata_i[1:0]);
  assign split    = !comp && offset_q == LAST;
  assign accept   = state_q == OUT && instr_ready_i;
  assign fetch_go = !adp_empty_i && (state_q == FETCH || accept);
  assign adp_re_o = !redirect_i && !adp_empty_i &&
                    (state_q == SKIP ? skip_q != '0 : state_q == OUT ? instr_ready_i : 1'b1);
  // a 32-bit parcel at the last halfword of a line is read as two halves
  assign adp_rsize_o        = (state_q == FETCH || state_q == OUT) && !comp && !split;
  assign fetch_flush_o      = redirect_i;
  assign instr_o            = instr_q;
  assign instr_pc_o         = pc_q;
  assign instr_compressed_o = comp_q;
  assign instr_valid_o      = state_q == OUT;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= SKIP;
      pc_q     <= BOOT_PC & ~32'h1;
      offset_q <= '0;
      skip_q   <= BOOT_PC[OW-1:1];
      instr_q  <= '0;
      comp_q   <= 1'b0;
    end else if (redirect_i) begin
      state_q  <= SKIP;
      pc_q     <= redirect_pc_i & ~32'h1;
      offset_q <= '0;
      skip_q   <= redirect_pc_i[OW-1:1];
    end else begin
      if (adp_re_o) offset_q <= offset_q + (adp_rsize_o ? OW'(4) : OW'(2));
      if (accept) pc_q <= pc_q + (comp_q ? 32'd2 : 32'd4);
      case (state_q)
        SKIP: begin
          if (skip_q == '0) state_q <= FETCH;
          else if (!adp_empty_i) skip_q <= skip_q - 1'b1;
        end
        FETCH, OUT: begin
          if (fetch_go) begin
            instr_q <= {(comp || split) ? 16'h0 : adp_rdata_i[31:16], adp_rdata_i[15:0]};
            comp_q  <= comp;
            state_q <= split ? FETCH_HI : OUT;
          end else if (accept) begin
            state_q <= FETCH;
          end
        end
        FETCH_HI: begin
          if (!adp_empty_i) begin
            instr_q[31:16] <= adp_rdata_i[15:0];
            state_q        <= OUT;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_parcel_sequencer.sv
// tb_fetch_parcel_sequencer: adapter model plus ISA-level scoreboard of delivered instructions
module tb_fetch_parcel_sequencer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
  } exp_t;

  logic        clk = 0, rstn = 0, empty = 0, re, rsize, flush, redirect = 0;
  logic        ic, valid, ready = 0;
  logic [31:0] rdata, rpc = 0, instr, ipc, addr, model_pc, cap_i, cap_p;
  logic [15:0] hmem [0:511];
  exp_t        q[$];
  int          errs = 0, checks = 0;
  bit          found;

  fetch_parcel_sequencer dut (
    .clk_i(clk), .rstn_i(rstn), .adp_empty_i(empty), .adp_rdata_i(rdata),
    .adp_re_o(re), .adp_rsize_o(rsize), .fetch_flush_o(flush),
    .redirect_i(redirect), .redirect_pc_i(rpc), .instr_o(instr), .instr_pc_o(ipc),
    .instr_compressed_o(ic), .instr_valid_o(valid), .instr_ready_i(ready)
  );

  always #5 clk = ~clk;

  assign rdata = {hmem[addr[9:1] + 9'd1], hmem[addr[9:1]]};
  always @(posedge clk) begin
    if (!rstn) addr <= 32'h0;
    else if (flush) addr <= rpc & ~32'hF;
    else if (re) addr <= addr + (rsize ? 32'd4 : 32'd2);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] lo, hi;
      lo = hmem[model_pc[9:1]];
      hi = hmem[model_pc[9:1] + 9'd1];
      if (lo[1:0] != 2'b11) begin
        q.push_back('{model_pc, {16'h0, lo}, 1'b1});
        model_pc += 2;
      end else begin
        q.push_back('{model_pc, {hi, lo}, 1'b0});
        model_pc += 4;
      end
    end
  endtask

  task automatic run(input int budget, input bit rnd, input bit tog);
    for (int n = 0; n < budget && q.size() != 0; n++) begin
      @(posedge clk); #1;
      ready = q.size() != 0 && (!rnd || $urandom_range(1) == 1);
      if (tog) empty = !empty;
    end
    ready = 0;
    empty = 0;
    chk("drain", q.size(), 0);
  endtask

  task automatic wait_valid();
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge clk); #1;
      found = valid;
    end
    chk("wait_valid", {31'b0, found}, 1);
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input bit rdy);
    @(posedge clk); #1;
    redirect = 1;
    rpc = tgt;
    ready = rdy;
    @(negedge clk);
    chk("flush_on", {31'b0, flush}, 1);
    chk("re_on_redirect", {31'b0, re}, 0);
    @(posedge clk); #1;
    redirect = 0;
    ready = 0;
    q.delete();
    model_pc = tgt;
    @(negedge clk);
    chk("flush_off", {31'b0, flush}, 0);
    chk("valid_after_redirect", {31'b0, valid}, 0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      chk("re_while_empty", {31'b0, re & empty}, 0);
      chk("split_read", {31'b0, re && rsize && addr[3:0] == 4'hE}, 0);
      if (valid && ready) begin
        if (q.size() == 0) chk("unexpected_instr", {31'b0, valid}, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("pc", ipc, e.pc);
          chk("instr", instr, e.ins);
          chk("compressed", {31'b0, ic}, {31'b0, e.c});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) hmem[i] = 16'($urandom);
    hmem[0] = 16'h0013; hmem[1] = 16'h0000; hmem[2] = 16'h4501; hmem[3] = 16'h4581;
    hmem[4] = 16'h0093; hmem[5] = 16'h00A0; hmem[6] = 16'h0001; hmem[7] = 16'h0113;
    hmem[8] = 16'h00B0;
    hmem[9'h107] = hmem[9'h107] | 16'h0003;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_re", {31'b0, re}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_pc", ipc, 0);
    // boot line: 32-bit, two compressed, 32-bit, compressed, line-split 32-bit
    q.push_back('{32'h0, 32'h0000_0013, 1'b0});
    q.push_back('{32'h4, 32'h0000_4501, 1'b1});
    q.push_back('{32'h6, 32'h0000_4581, 1'b1});
    q.push_back('{32'h8, 32'h00A0_0093, 1'b0});
    q.push_back('{32'hC, 32'h0000_0001, 1'b1});
    q.push_back('{32'hE, 32'h00B0_0113, 1'b0});
    model_pc = 32'h12;
    push_n(6);
    run(200, 0, 0);
    // hold the next instruction for five cycles
    wait_valid();
    push_n(4);
    cap_i = instr;
    cap_p = ipc;
    chk("stall_head_pc", ipc, q[0].pc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_instr", instr, cap_i);
      chk("stall_pc", ipc, cap_p);
      chk("stall_re", {31'b0, re}, 0);
      chk("stall_valid", {31'b0, valid}, 1);
    end
    run(200, 0, 0);
    do_redirect(32'h106, 0);
    push_n(6);
    run(200, 0, 0);
    // redirect in the same cycle as an accept
    wait_valid();
    push_n(1);
    do_redirect(32'h20E, 1);
    chk("accept_with_redirect", q.size(), 0);
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(posedge clk); #1;
      found = dut.state_q == fetch_pkg::FETCH_HI;
    end
    chk("reach_fetch_hi", {31'b0, found}, 1);
    do_redirect(32'h300, 0);
    push_n(40);
    run(3000, 1, 1);
    // reset in the middle of delivery
    wait_valid();
    @(posedge clk); #1;
    rstn = 0;
    q.delete();
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, valid}, 0);
    chk("mid_rst_pc", ipc, 0);
    model_pc = 0;
    push_n(6);
    run(200, 1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
